// File: rtl/tinyalu_pkg.sv
// Shared types for the ALU issue queue: opcodes, queued instruction record and FSM states.
package tinyalu_pkg;

    // Operand fields are sized for the widest supported DATA_W; narrower
    // instances zero-extend and the unused upper bits trim away.
    localparam int MAX_DATA_W = 32;

    typedef enum logic [2:0] {
        no_op  = 3'd0,
        add_op = 3'd1,
        and_op = 3'd2,
        xor_op = 3'd3,
        mul_op = 3'd4
    } opcode_e;

    typedef struct packed {
        logic [MAX_DATA_W-1:0] a;
        logic [MAX_DATA_W-1:0] b;
        logic [2:0]            op;
    } instr_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    function automatic logic is_alu_op(input logic [2:0] op);
        return (op >= add_op) && (op <= mul_op);
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO with combinational head read; pointers wrap naturally since DEPTH is a power of two.
module instr_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_reg == (PTR_W+1)'(DEPTH));
    assign empty    = (count_reg == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr_reg];
    assign count    = count_reg;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
                2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_queue.sv
// Queues ALU instructions, issues them one at a time to an external ALU and
// returns one response per instruction, with bypass for no-op/illegal ops and a done timeout.
module alu_issue_queue
    import tinyalu_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_a,
    input  logic [DATA_W-1:0]      in_b,
    input  logic [2:0]             in_op,
    output logic                   alu_start,
    output logic [DATA_W-1:0]      alu_a,
    output logic [DATA_W-1:0]      alu_b,
    output logic [2:0]             alu_op,
    input  logic                   alu_done,
    input  logic [2*DATA_W-1:0]    alu_result,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*DATA_W-1:0]    out_result,
    output logic [2:0]             out_op,
    output logic                   out_err,
    output logic                   out_timeout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   busy
);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    instr_t              push_instr;
    instr_t              head_instr;
    logic [$bits(instr_t)-1:0] unused_head;
    logic                fifo_full;
    logic                fifo_empty;
    logic                launch;
    logic                head_is_alu;
    logic                tmo_hit;
    state_e              state_reg;
    state_e              state_next;
    logic [TMO_W-1:0]    tmo_cnt_reg;
    logic [DATA_W-1:0]   alu_a_reg;
    logic [DATA_W-1:0]   alu_b_reg;
    logic [2:0]          alu_op_reg;
    logic [2*DATA_W-1:0] out_result_reg;
    logic                out_err_reg;
    logic                out_timeout_reg;

    always_comb begin
        push_instr                = '0;
        push_instr.a[DATA_W-1:0]  = in_a;
        push_instr.b[DATA_W-1:0]  = in_b;
        push_instr.op             = in_op;
    end

    instr_fifo #(
        .WIDTH($bits(instr_t)),
        .DEPTH(DEPTH)
    ) u_instr_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (in_valid && in_ready),
        .push_data (push_instr),
        .pop       (launch),
        .pop_data  (head_instr),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (count)
    );

    assign unused_head = head_instr;

    // A new instruction leaves the queue from IDLE, or straight from RESP on
    // the edge its predecessor's response is accepted.
    assign launch      = !fifo_empty &&
                         ((state_reg == IDLE) || ((state_reg == RESP) && out_ready));
    assign head_is_alu = is_alu_op(head_instr.op);
    assign tmo_hit     = (tmo_cnt_reg == TMO_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (launch) state_next = head_is_alu ? EXEC : RESP;
            EXEC: if (alu_done || tmo_hit) state_next = RESP;
            RESP: begin
                if (out_ready) begin
                    if (launch) state_next = head_is_alu ? EXEC : RESP;
                    else        state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt_reg     <= '0;
            alu_a_reg       <= '0;
            alu_b_reg       <= '0;
            alu_op_reg      <= '0;
            out_result_reg  <= '0;
            out_err_reg     <= 1'b0;
            out_timeout_reg <= 1'b0;
        end else if (launch) begin
            alu_a_reg   <= head_instr.a[DATA_W-1:0];
            alu_b_reg   <= head_instr.b[DATA_W-1:0];
            alu_op_reg  <= head_instr.op;
            tmo_cnt_reg <= '0;
            if (!head_is_alu) begin
                out_result_reg  <= '0;
                out_err_reg     <= (head_instr.op > mul_op);
                out_timeout_reg <= 1'b0;
            end
        end else if (state_reg == EXEC) begin
            if (alu_done) begin
                out_result_reg  <= alu_result;
                out_err_reg     <= 1'b0;
                out_timeout_reg <= 1'b0;
            end else if (tmo_hit) begin
                out_result_reg  <= '0;
                out_err_reg     <= 1'b0;
                out_timeout_reg <= 1'b1;
            end else begin
                tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
            end
        end
    end

    assign in_ready    = !fifo_full;
    assign alu_start   = (state_reg == EXEC);
    assign alu_a       = alu_a_reg;
    assign alu_b       = alu_b_reg;
    assign alu_op      = alu_op_reg;
    assign out_valid   = (state_reg == RESP);
    assign out_result  = out_result_reg;
    assign out_op      = alu_op_reg;
    assign out_err     = out_err_reg;
    assign out_timeout = out_timeout_reg;
    assign busy        = (state_reg != IDLE) || (count != '0);

endmodule

// File: tb/tb_alu_issue_queue.sv
// Bench for alu_issue_queue: directed vector table, corner-case sequences and a randomized scoreboard run.
module tb_alu_issue_queue;
    localparam int DATA_W  = 8;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 10;
    localparam int HANG    = 255;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_a = '0, in_b = '0;
    logic [2:0]  in_op = '0;
    logic        alu_start;
    logic [7:0]  alu_a, alu_b;
    logic [2:0]  alu_op;
    logic        alu_done = 1'b0;
    logic [15:0] alu_result = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_result;
    logic [2:0]  out_op;
    logic        out_err, out_timeout;
    logic [2:0]  count;
    logic        busy;

    always #5 clk = ~clk;

    alu_issue_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .alu_start(alu_start), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_done(alu_done), .alu_result(alu_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_op(out_op),
        .out_err(out_err), .out_timeout(out_timeout), .count(count), .busy(busy)
    );

    typedef struct {
        logic [15:0] result;
        logic [2:0]  op;
        logic        err;
        logic        tmo;
    } resp_t;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [2:0]  op;
        int          lat;
        logic [15:0] result;
        logic        err;
        logic        tmo;
        int          cyc;
    } vec_t;

    int    errors = 0;
    int    checks = 0;
    int    resp_cnt = 0;
    resp_t exp_q[$];
    int    lat_q[$];
    bit    mon_en = 0;
    bit    stray_en = 0;
    bit    start_seen = 0;
    bit    pushes_done = 0;
    int    exec_cyc = 0;
    int    cur_lat = 0;
    vec_t  vt[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    function automatic logic [15:0] alu_math(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        case (op)
            3'd1:    return 16'(a) + 16'(b);
            3'd2:    return {8'h00, a & b};
            3'd3:    return {8'h00, a ^ b};
            3'd4:    return 16'(a) * 16'(b);
            default: return 16'h0000;
        endcase
    endfunction

    // Expected response: ALU ops that would finish later than TIMEOUT cycles time out.
    function automatic resp_t model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op, input int lat);
        resp_t r;
        r.op = op; r.err = 1'b0; r.tmo = 1'b0; r.result = '0;
        if (op >= 3'd5)          r.err = 1'b1;
        else if (op == 3'd0)     r.result = '0;
        else if (lat > TIMEOUT)  r.tmo = 1'b1;
        else                     r.result = alu_math(a, b, op);
        return r;
    endfunction

    // ALU stand-in: answers each request after its planned latency, plus optional stray pulses.
    always @(negedge clk) begin
        alu_done   = 1'b0;
        alu_result = '0;
        if (alu_start) begin
            start_seen = 1'b1;
            if (exec_cyc == 0) cur_lat = (lat_q.size() > 0) ? lat_q.pop_front() : 1;
            exec_cyc++;
            if (exec_cyc == cur_lat) begin
                alu_done   = 1'b1;
                alu_result = alu_math(alu_a, alu_b, alu_op);
            end
        end else begin
            exec_cyc = 0;
            if (stray_en && $urandom_range(0, 7) == 0) begin
                alu_done   = 1'b1;
                alu_result = 16'($urandom);
            end
        end
    end

    always @(negedge clk) begin
        resp_t e;
        #1;
        if (mon_en && !reset) begin
            chk("in_ready_vs_count", {31'd0, in_ready}, {31'd0, (count < 3'(DEPTH))});
            if (out_valid && out_ready) begin
                resp_cnt++;
                if (exp_q.size() == 0) begin
                    chk("stale_response_valid", {31'd0, out_valid}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_result", {16'd0, out_result}, {16'd0, e.result});
                    chk("resp_op", {29'd0, out_op}, {29'd0, e.op});
                    chk("resp_err", {31'd0, out_err}, {31'd0, e.err});
                    chk("resp_timeout", {31'd0, out_timeout}, {31'd0, e.tmo});
                end
            end
        end
    end

    // Called just after a negedge; returns at the negedge following the accepting edge.
    task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op, input int lat);
        bit ok = 0;
        in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
        for (int k = 0; k < 300 && !ok; k++) begin
            if (in_ready) begin
                exp_q.push_back(model(a, b, op, lat));
                if (op >= 3'd1 && op <= 3'd4) lat_q.push_back(lat);
                ok = 1;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!ok) fail("push_accept");
    endtask

    task automatic drain(input string name);
        int k = 0;
        while ((exp_q.size() > 0 || busy) && k < 800) begin
            @(negedge clk);
            k++;
        end
        #2;
        if (k >= 800) fail(name);
    endtask

    initial begin
        vt[0]  = '{8'd100, 8'd55,  3'd1, 3,    16'd155,   1'b0, 1'b0, 3};
        vt[1]  = '{8'd200, 8'd100, 3'd1, 1,    16'd300,   1'b0, 1'b0, 1};
        vt[2]  = '{8'hF0,  8'h3C,  3'd2, 2,    16'h0030,  1'b0, 1'b0, 2};
        vt[3]  = '{8'hAA,  8'hFF,  3'd3, 5,    16'h0055,  1'b0, 1'b0, 5};
        vt[4]  = '{8'd255, 8'd255, 3'd4, HANG, 16'h0000,  1'b0, 1'b1, 10};
        vt[5]  = '{8'd255, 8'd255, 3'd4, 4,    16'hFE01,  1'b0, 1'b0, 4};
        vt[6]  = '{8'h10,  8'h10,  3'd4, 10,   16'h0100,  1'b0, 1'b0, 10};
        vt[7]  = '{8'h07,  8'h09,  3'd0, 0,    16'h0000,  1'b0, 1'b0, 0};
        vt[8]  = '{8'h01,  8'h02,  3'd6, 0,    16'h0000,  1'b1, 1'b0, 0};
        vt[9]  = '{8'h33,  8'h44,  3'd5, 0,    16'h0000,  1'b1, 1'b0, 0};
        vt[10] = '{8'h55,  8'h66,  3'd7, 0,    16'h0000,  1'b1, 1'b0, 0};
        vt[11] = '{8'hFF,  8'hFF,  3'd1, 9,    16'h01FE,  1'b0, 1'b0, 9};
        vt[12] = '{8'h00,  8'hFF,  3'd2, 1,    16'h0000,  1'b0, 1'b0, 1};

        // Reset values
        repeat (3) @(negedge clk);
        #1;
        chk("rst_count", {29'd0, count}, 32'd0);
        chk("rst_alu_start", {31'd0, alu_start}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_result", {16'd0, out_result}, 32'd0);
        chk("rst_out_err", {31'd0, out_err}, 32'd0);
        chk("rst_out_timeout", {31'd0, out_timeout}, 32'd0);
        chk("rst_alu_ab", {16'd0, alu_a, alu_b}, 32'd0);
        chk("rst_alu_op", {29'd0, alu_op}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_in_ready_after", {31'd0, in_ready}, 32'd1);

        // Directed vectors, one instruction at a time
        out_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            automatic int cyc = 0;
            automatic int first = 0;
            automatic int n = 1;
            automatic bit got = 0;
            push(vt[i].a, vt[i].b, vt[i].op, vt[i].lat);
            while (!got && n < 40) begin
                if (alu_start) begin
                    cyc++;
                    if (first == 0) first = n;
                end
                if (out_valid) begin
                    got = 1;
                    chk($sformatf("v%0d_result", i), {16'd0, out_result}, {16'd0, vt[i].result});
                    chk($sformatf("v%0d_op", i), {29'd0, out_op}, {29'd0, vt[i].op});
                    chk($sformatf("v%0d_err", i), {31'd0, out_err}, {31'd0, vt[i].err});
                    chk($sformatf("v%0d_timeout", i), {31'd0, out_timeout}, {31'd0, vt[i].tmo});
                    chk($sformatf("v%0d_exec_cycles", i), cyc, vt[i].cyc);
                    chk($sformatf("v%0d_start_low_in_resp", i), {31'd0, alu_start}, 32'd0);
                    if (vt[i].cyc > 0) chk($sformatf("v%0d_start_latency", i), first, 2);
                end else begin
                    @(negedge clk);
                    n++;
                end
            end
            if (!got) fail($sformatf("v%0d_response", i));
            @(negedge clk);
            chk($sformatf("v%0d_idle_after", i), {31'd0, busy}, 32'd0);
            exp_q.delete();
            lat_q.delete();
        end

        // Fill with responses blocked, then release
        mon_en = 1;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(8'(i + 1), 8'h0F, 3'd3, 2);
        repeat (5) @(negedge clk);
        chk("fill_count", {29'd0, count}, 32'd4);
        chk("fill_in_ready", {31'd0, in_ready}, 32'd0);
        chk("fill_out_valid", {31'd0, out_valid}, 32'd1);
        chk("fill_head_result", {16'd0, out_result}, 32'h0E);
        fork
            push(8'h66, 8'h0F, 3'd3, 2);
            begin
                repeat (4) @(negedge clk);
                chk("fill_hold_count", {29'd0, count}, 32'd4);
                chk("fill_hold_result", {16'd0, out_result}, 32'h0E);
                out_ready = 1'b1;
            end
        join
        drain("fill_drain");
        chk("fill_resp_total", resp_cnt, 6);
        chk("fill_end_count", {29'd0, count}, 32'd0);

        // Bypass ops never reach the ALU
        start_seen = 0;
        resp_cnt = 0;
        push(8'h07, 8'h09, 3'd0, 0);
        push(8'h01, 8'h02, 3'd6, 0);
        drain("bypass_drain");
        chk("bypass_no_start", {31'd0, start_seen}, 32'd0);
        chk("bypass_resp_total", resp_cnt, 2);

        // Reset during the first EXEC discards everything
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(8'hFF, 8'hFF, 3'd4, HANG);
        begin
            automatic int k = 0;
            while (!alu_start && k < 20) begin @(negedge clk); k++; end
            if (!alu_start) fail("rst_mid_exec_start");
        end
        reset = 1'b1;
        #1;
        chk("midrst_count", {29'd0, count}, 32'd0);
        chk("midrst_alu_start", {31'd0, alu_start}, 32'd0);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        exp_q.delete();
        lat_q.delete();
        reset = 1'b0;
        #1;
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        resp_cnt = 0;
        out_ready = 1'b1;
        repeat (20) @(negedge clk);
        #2;
        chk("midrst_no_stale", resp_cnt, 0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);

        // Back-to-back issue with out_ready held high
        fork
            for (int i = 0; i < 4; i++) push(8'($urandom), 8'($urandom), 3'd3, 2);
            begin
                automatic int acc = 0;
                automatic int k = 0;
                automatic bit pend = 0;
                while (acc < 4 && k < 200) begin
                    @(negedge clk);
                    k++;
                    if (pend) begin
                        chk("b2b_restart", {31'd0, alu_start}, 32'd1);
                        pend = 0;
                    end
                    if (out_valid && out_ready) begin
                        acc++;
                        pend = (acc < 4);
                    end
                end
                if (acc < 4) fail("b2b_responses");
            end
        join
        drain("b2b_drain");

        // Randomized traffic with stray done pulses and random backpressure
        stray_en = 1;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    automatic int r = $urandom_range(0, 15);
                    automatic logic [2:0] op = (r < 12) ? 3'(1 + r % 4) : 3'($urandom_range(0, 7));
                    automatic int lat = ($urandom_range(0, 7) == 0) ? HANG : $urandom_range(1, TIMEOUT);
                    push(8'($urandom), 8'($urandom), op, lat);
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                end
                pushes_done = 1;
            end
            begin
                while (!pushes_done) begin
                    @(negedge clk);
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain("random_drain");
        chk("random_end_count", {29'd0, count}, 32'd0);
        chk("random_end_valid", {31'd0, out_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
